// File: rtl/guard_pkg.sv
// Shared definitions for the guarded serial link: frame states, default width
// and the bit positions of the status fields in the receiver output word.
package guard_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int FRAME_LEN      = DATA_W_DEFAULT + 3;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  // Output word is {valid, frame_err, parity_err, data}; status bits sit above the payload.
  function automatic int validPos(input int dataW);
    return dataW + 2;
  endfunction

  function automatic int frameErrPos(input int dataW);
    return dataW + 1;
  endfunction

  function automatic int parityErrPos(input int dataW);
    return dataW;
  endfunction

endpackage

// File: rtl/guard_rx_shift.sv
// LSB-first receive shift register with a running even-parity accumulator.
module guard_rx_shift
  import guard_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clear,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data,
  output logic              parity
);

  // New bits enter at the MSB so the first bit received ends up in data[0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data   <= '0;
      parity <= 1'b0;
    end else if (clear) begin
      data   <= '0;
      parity <= 1'b0;
    end else if (shift_en) begin
      data   <= {bit_in, data[DATA_W-1:1]};
      parity <= parity ^ bit_in;
    end
  end

endmodule

// File: rtl/guard_frame_rx.sv
// Serial frame receiver: start, DATA_W bits LSB first, even parity, stop.
// Reports every frame (including bad ones) with a one-cycle valid pulse.
module guard_frame_rx
  import guard_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              __in0,
  output logic [DATA_W+2:0] __out0
);

  localparam int CNT_W      = $clog2(DATA_W + 1);
  localparam int VALID_POS  = validPos(DATA_W);
  localparam int FERR_POS   = frameErrPos(DATA_W);
  localparam int PERR_POS   = parityErrPos(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);

  state_t              r_state;
  logic [CNT_W-1:0]    r_bitCnt;
  logic                r_parBit;
  logic [DATA_W+2:0]   r_out;

  logic                w_shiftEn;
  logic                w_clear;
  logic [DATA_W-1:0]   w_data;
  logic                w_parity;

  assign w_shiftEn = (r_state == DATA);
  assign w_clear   = (r_state == IDLE) && !__in0;
  assign __out0    = r_out;

  guard_rx_shift #(
    .DATA_W(DATA_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .shift_en(w_shiftEn),
    .clear   (w_clear),
    .bit_in  (__in0),
    .data    (w_data),
    .parity  (w_parity)
  );

  // The result word is loaded on the edge that samples the stop bit, so it is
  // visible the following cycle; valid self-clears on every other edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_bitCnt <= '0;
      r_parBit <= 1'b0;
      r_out    <= '0;
    end else begin
      r_out[VALID_POS] <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!__in0) begin
            r_state  <= DATA;
            r_bitCnt <= '0;
          end
        end
        DATA: begin
          if (r_bitCnt != CNT_MAX) begin
            r_bitCnt <= r_bitCnt + CNT_W'(1);
          end
          if (r_bitCnt == LAST_BIT) begin
            r_state <= PARITY;
          end
        end
        PARITY: begin
          r_parBit <= __in0;
          r_state  <= STOP;
        end
        STOP: begin
          r_out[VALID_POS]    <= 1'b1;
          r_out[FERR_POS]     <= !__in0;
          r_out[PERR_POS]     <= r_parBit ^ w_parity;
          r_out[DATA_W-1:0]   <= w_data;
          // A low stop bit must not be mistaken for the next start bit.
          r_state <= __in0 ? IDLE : BREAK;
        end
        BREAK: begin
          if (__in0) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_guard_frame_rx.sv
// Self-checking bench for guard_frame_rx: directed frame table, multi-cycle
// corner sequences and a randomized bit stream checked against a frame model.
module tb_guard_frame_rx;
  import guard_pkg::*;

  localparam int W  = DATA_W_DEFAULT;
  localparam int OW = W + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in0 = 1'b1;
  logic [OW-1:0] out0;

  int checks    = 0;
  int errors    = 0;
  int stepCount = 0;
  int            pulseSteps[$];
  logic [OW-1:0] pulseVals[$];

  typedef struct {
    logic [W-1:0]  data;
    logic          parBit;
    logic          stopBit;
    logic [OW-1:0] expOut;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  guard_frame_rx #(.DATA_W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .__in0 (in0),
    .__out0(out0)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One line bit per call; outputs are observed on the falling edge that follows.
  task automatic stepBit(input logic b);
    in0 = b;
    @(negedge clk);
    stepCount++;
    if (out0[OW-1]) begin
      pulseSteps.push_back(stepCount);
      pulseVals.push_back(out0);
    end
  endtask

  task automatic clearPulses();
    pulseSteps.delete();
    pulseVals.delete();
    stepCount = 0;
  endtask

  task automatic applyStimulus(input logic [W-1:0] data, input logic parBit, input logic stopBit);
    stepBit(1'b0);
    for (int i = 0; i < W; i++) stepBit(data[i]);
    stepBit(parBit);
    stepBit(stopBit);
  endtask

  task automatic checkOutput(input string name, input logic [OW-1:0] actual, input logic [OW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [OW-1:0] pulseVal(input int idx);
    if (idx < pulseVals.size()) return pulseVals[idx];
    return 'x;
  endfunction

  function automatic int pulseStep(input int idx);
    if (idx < pulseSteps.size()) return pulseSteps[idx];
    return -1;
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    in0 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic          bitsQ[$];
    logic [OW-1:0] expQ[$];
    logic [OW-1:0] held;
    logic [OW-1:0] pulse;
    logic [W-1:0]  rd;
    logic          goodPar;
    logic          rp;
    logic          rs;
    logic          prevErr;
    int            gap;

    vecs[0] = '{8'h01, 1'b0, 1'b1, 11'h501};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 11'h63C};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 11'h400};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 11'h4FF};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 11'h580};
    vecs[5] = '{8'h7F, 1'b1, 1'b1, 11'h47F};
    vecs[6] = '{8'h55, 1'b1, 1'b0, 11'h755};
    vecs[7] = '{8'hC3, 1'b1, 1'b1, 11'h5C3};

    rst = 1'b0;
    in0 = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset state", out0, '0);
    rst = 1'b1;

    // Idle line must produce nothing.
    clearPulses();
    repeat (20) stepBit(1'b1);
    checkInt("idle pulse count", pulseSteps.size(), 0);
    checkOutput("idle output", out0, '0);

    // Good frame with latency and hold check.
    clearPulses();
    applyStimulus(8'hA5, 1'b0, 1'b1);
    checkInt("good latency", pulseStep(0), 11);
    checkOutput("good pulse", out0, 11'h4A5);
    stepBit(1'b1);
    checkOutput("good hold", out0, 11'h0A5);
    checkInt("good pulse count", pulseSteps.size(), 1);

    for (int v = 0; v < 8; v++) begin
      clearPulses();
      applyStimulus(vecs[v].data, vecs[v].parBit, vecs[v].stopBit);
      checkOutput($sformatf("vec%0d pulse", v), out0, vecs[v].expOut);
      stepBit(1'b1);
      checkOutput($sformatf("vec%0d hold", v), out0, {1'b0, vecs[v].expOut[OW-2:0]});
      checkInt($sformatf("vec%0d pulse count", v), pulseSteps.size(), 1);
    end

    // Frame error followed by a long low line: one pulse only.
    stepBit(1'b1);
    clearPulses();
    applyStimulus(8'h3C, 1'b0, 1'b0);
    repeat (20) stepBit(1'b0);
    checkInt("break pulse count", pulseSteps.size(), 1);
    checkOutput("break pulse value", pulseVal(0), 11'h63C);
    checkOutput("break hold", out0, 11'h23C);
    repeat (3) stepBit(1'b1);
    checkInt("break idle pulse count", pulseSteps.size(), 1);
    applyStimulus(8'hA5, 1'b0, 1'b1);
    checkInt("after break pulse count", pulseSteps.size(), 2);
    checkOutput("after break pulse", out0, 11'h4A5);

    // Back-to-back frames.
    stepBit(1'b1);
    clearPulses();
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b0, 1'b1);
    checkInt("b2b pulse count", pulseSteps.size(), 2);
    checkInt("b2b spacing", pulseStep(1) - pulseStep(0), 11);
    checkOutput("b2b first", pulseVal(0), 11'h400);
    checkOutput("b2b second", pulseVal(1), 11'h4FF);

    // Reset in the middle of a frame.
    stepBit(1'b1);
    checkOutput("pre-reset hold", out0, 11'h0FF);
    stepBit(1'b0);
    stepBit(1'b0);
    stepBit(1'b1);
    stepBit(1'b0);
    stepBit(1'b1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset clears", out0, '0);
    in0 = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("held in reset", out0, '0);
    rst = 1'b1;
    clearPulses();
    applyStimulus(8'h5A, 1'b0, 1'b1);
    checkOutput("post-reset pulse", out0, 11'h45A);
    repeat (3) stepBit(1'b1);
    checkInt("post-reset pulse count", pulseSteps.size(), 1);
    checkInt("post-reset latency", pulseStep(0), 11);

    // Randomized stream: expected output per bit derived from the frames generated.
    doReset();
    held    = '0;
    prevErr = 1'b0;
    for (int f = 0; f < 40; f++) begin
      gap = prevErr ? 1 + int'($urandom_range(2)) : int'($urandom_range(3));
      for (int g = 0; g < gap; g++) begin
        bitsQ.push_back(1'b1);
        expQ.push_back(held);
      end
      rd      = W'($urandom);
      goodPar = ^rd;
      rp      = ($urandom_range(3) == 0) ? ~goodPar : goodPar;
      rs      = ($urandom_range(3) != 0);
      bitsQ.push_back(1'b0);
      expQ.push_back(held);
      for (int i = 0; i < W; i++) begin
        bitsQ.push_back(rd[i]);
        expQ.push_back(held);
      end
      bitsQ.push_back(rp);
      expQ.push_back(held);
      pulse = {1'b1, ~rs, (rp != goodPar), rd};
      bitsQ.push_back(rs);
      expQ.push_back(pulse);
      held = {1'b0, pulse[OW-2:0]};
      prevErr = ~rs;
      if (!rs) begin
        for (int z = 0; z < int'($urandom_range(3)); z++) begin
          bitsQ.push_back(1'b0);
          expQ.push_back(held);
        end
      end
    end
    bitsQ.push_back(1'b1);
    expQ.push_back(held);
    bitsQ.push_back(1'b1);
    expQ.push_back(held);

    for (int i = 0; i < bitsQ.size(); i++) begin
      stepBit(bitsQ[i]);
      checkOutput($sformatf("random step %0d", i), out0, expQ[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
